aes_shiftrows_pipe: RTL and testbench

Pipelined, parametrised Rijndael ShiftRows/InvShiftRows unit with valid/ready flow control, used between the SubBytes and MixColumns stages of the iterative and unrolled AES datapaths. Generalises the combinational AES ShiftRows to Rijndael block widths Nb = 4/6/8. Direction is selected per beat, so one instance serves both encrypt and decrypt rounds. A sideband tag travels with each beat, and a synchronous flush drops all in-flight data.

---
 rtl/aes_shiftrows_pipe.sv | 168 ++++++++++++++++
 tb/tb_aes_shiftrows_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shiftrows_pipe.sv
// aes_shiftrows_pipe
//
// Pipelined Rijndael ShiftRows / InvShiftRows unit with valid/ready flow
// control. The unit supports Rijndael block widths of 4, 6 or 8 columns.
// The byte permutation is applied combinationally in front of stage 1.
// Any later stages only carry data, mode and tag forward. The ready chain
// is combinational from the output back to the input, so a full pipeline
// can pop, shift and accept in the same cycle.
//
// Parameters
//   NB          state columns (4, 6 or 8); state width W = 32*NB
//   PIPE_STAGES register stages (1..4)
//   TAG_W       sideband tag width (>= 1)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous drop of every in-flight beat
//   in_valid/in_ready input handshake
//   in_data/in_inv    input state, 0 = ShiftRows, 1 = InvShiftRows
//   in_tag            sideband, passed through unchanged
//   out_valid/out_ready output handshake
//   out_data/out_inv/out_tag  contents of the last stage
//   occupancy         number of valid stages
module aes_shiftrows_pipe #(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*NB-1:0]    in_data,
  input  logic                in_inv,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_data,
  output logic                out_inv,
  output logic [TAG_W-1:0]    out_tag,
  output logic [2:0]          occupancy
);

  localparam int W      = 32 * NB;
  localparam int NBYTES = 4 * NB;
  localparam int LAST   = PIPE_STAGES - 1;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $fatal(1, "aes_shiftrows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $fatal(1, "aes_shiftrows_pipe: PIPE_STAGES must be 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $fatal(1, "aes_shiftrows_pipe: TAG_W must be at least 1");
  end

  // Byte permutation. Output byte k = 4c + r takes its value from row r of
  // source column (c +/- s_r) mod NB. For NB = 8, rows 2 and 3 shift by
  // 3 and 4 instead of 2 and 3.
  logic [W-1:0] fwd_data;
  logic [W-1:0] inv_data;
  logic [W-1:0] perm_data;

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    localparam int R    = gi % 4;
    localparam int C    = gi / 4;
    localparam int S    = (NB == 8 && R >= 2) ? R + 1 : R;
    localparam int FSRC = 4 * ((C + S) % NB) + R;
    localparam int ISRC = 4 * ((C - S + NB) % NB) + R;
    assign fwd_data[8*gi +: 8] = in_data[8*FSRC +: 8];
    assign inv_data[8*gi +: 8] = in_data[8*ISRC +: 8];
  end

  assign perm_data = in_inv ? inv_data : fwd_data;

  // Pipeline state
  logic [PIPE_STAGES-1:0] v_q, v_d;
  logic [PIPE_STAGES-1:0] inv_q, inv_d;
  logic [W-1:0]           data_q [PIPE_STAGES];
  logic [W-1:0]           data_d [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_d  [PIPE_STAGES];
  logic [2:0]             occupancy_q, occupancy_d;
  logic [PIPE_STAGES-1:0] ld;
  logic                   in_fire;

  // Load chain. A stage loads when it is empty or when its content moves on.
  // The chain is resolved from the output end back toward the input.
  always_comb begin
    ld       = '0;
    ld[LAST] = !v_q[LAST] || out_ready;
    for (int i = LAST - 1; i >= 0; i--) begin
      ld[i] = !v_q[i] || ld[i+1];
    end
  end

  assign in_ready = !flush && ld[0];
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    v_d    = v_q;
    inv_d  = inv_q;
    data_d = data_q;
    tag_d  = tag_q;

    // Payload registers only capture on a real transfer, so an empty slot
    // keeps its previous payload and the output stays quiet while stalled.
    if (ld[0]) begin
      v_d[0] = in_fire;
      if (in_fire) begin
        data_d[0] = perm_data;
        inv_d[0]  = in_inv;
        tag_d[0]  = in_tag;
      end
    end

    for (int i = 1; i < PIPE_STAGES; i++) begin
      if (ld[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          data_d[i] = data_q[i-1];
          inv_d[i]  = inv_q[i-1];
          tag_d[i]  = tag_q[i-1];
        end
      end
    end

    if (flush) begin
      v_d = '0;
    end

    occupancy_d = '0;
    for (int i = 0; i < PIPE_STAGES; i++) begin
      if (v_d[i]) begin
        occupancy_d = occupancy_d + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      inv_q       <= '0;
      occupancy_q <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      v_q         <= v_d;
      inv_q       <= inv_d;
      occupancy_q <= occupancy_d;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_inv   = inv_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Testbench for aes_shiftrows_pipe.
// Instance A: NB = 4, PIPE_STAGES = 2. It is used for the directed vectors,
// the latency check, the round trip, flush and asynchronous reset.
// Instance B: NB = 8, PIPE_STAGES = 3. It is used for the wide vector and for
// the backpressure stream with mixed modes.
module tb_aes_shiftrows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A signals
  logic         a_flush, a_in_valid, a_in_ready, a_in_inv;
  logic [127:0] a_in_data, a_out_data;
  logic [3:0]   a_in_tag, a_out_tag;
  logic         a_out_valid, a_out_ready, a_out_inv;
  logic [2:0]   a_occ;

  // Instance B signals
  logic         b_flush, b_in_valid, b_in_ready, b_in_inv;
  logic [255:0] b_in_data, b_out_data;
  logic [3:0]   b_in_tag, b_out_tag;
  logic         b_out_valid, b_out_ready, b_out_inv;
  logic [2:0]   b_occ;

  aes_shiftrows_pipe #(.NB(4), .PIPE_STAGES(2), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_inv(a_in_inv), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_inv(a_out_inv), .out_tag(a_out_tag), .occupancy(a_occ)
  );

  aes_shiftrows_pipe #(.NB(8), .PIPE_STAGES(3), .TAG_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_inv(b_in_inv), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_inv(b_out_inv), .out_tag(b_out_tag), .occupancy(b_occ)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference permutation written as row/column moves over the state.
  function automatic logic [255:0] sr_model(input logic [255:0] d, input int nb, input bit inv);
    logic [255:0] o;
    int sh [4];
    int src;
    o = '0;
    sh[0] = 0; sh[1] = 1;
    if (nb == 8) begin sh[2] = 3; sh[3] = 4; end
    else         begin sh[2] = 2; sh[3] = 3; end
    for (int col = 0; col < nb; col++) begin
      for (int row = 0; row < 4; row++) begin
        src = inv ? (col - sh[row] + nb) % nb : (col + sh[row]) % nb;
        o[8*(4*col+row) +: 8] = d[8*(4*src+row) +: 8];
      end
    end
    return o;
  endfunction

  // One beat through instance A with out_ready high. lat counts clock edges
  // between acceptance and out_valid being seen.
  task automatic xfer_a(input logic [127:0] d, input logic inv, input logic [3:0] tag,
                        output logic [127:0] od, output logic oinv, output logic [3:0] otag,
                        output int lat);
    int waitc;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = d; a_in_inv = inv; a_in_tag = tag; a_out_ready = 1'b1;
    waitc = 0;
    #1;
    while (!a_in_ready && waitc < 20) begin @(negedge clk); #1; waitc++; end
    if (!a_in_ready) check_eq("a_accept_timeout", 256'(a_in_ready), 256'd1);
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 20) begin @(negedge clk); lat++; end
    od = a_out_data; oinv = a_out_inv; otag = a_out_tag;
  endtask

  localparam logic [127:0] IN16  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FWD16 = 128'h0b06010c07020d08030e09040f0a0500;
  localparam logic [127:0] INV16 = 128'h0306090c0f0205080b0e0104070a0d00;

  initial begin
    logic [127:0] od, rd, rnd;
    logic         oi;
    logic [3:0]   ot;
    int           lat;
    logic [255:0] d8;
    logic [255:0] bp_data [10];
    int           t_in, rx, cyc, seen;
    logic         prev_stalled;
    logic [255:0] prev_data;
    logic [3:0]   prev_tag;
    logic         will_in, will_out;

    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_in_inv = 0; a_in_tag = '0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_in_inv = 0; b_in_tag = '0; b_out_ready = 1;

    // Reset state
    #1;
    check_eq("rst_out_valid", 256'(a_out_valid), 256'd0);
    check_eq("rst_out_data", 256'(a_out_data), 256'd0);
    check_eq("rst_out_tag", 256'(a_out_tag), 256'd0);
    check_eq("rst_occupancy", 256'(a_occ), 256'd0);
    #11 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 256'(a_in_ready), 256'd1);

    // NB=4 forward
    xfer_a(IN16, 1'b0, 4'h3, od, oi, ot, lat);
    $display("beat a fwd: tag=%0h inv=%0b out=%032h lat=%0d", ot, oi, od, lat);
    check_eq("nb4_fwd_data", 256'(od), 256'(FWD16));
    check_eq("nb4_fwd_inv", 256'(oi), 256'd0);
    check_eq("nb4_fwd_tag", 256'(ot), 256'h3);
    check_eq("nb4_fwd_latency", 256'(lat), 256'd1);

    // NB=4 inverse
    xfer_a(IN16, 1'b1, 4'ha, od, oi, ot, lat);
    $display("beat a inv: tag=%0h inv=%0b out=%032h lat=%0d", ot, oi, od, lat);
    check_eq("nb4_inv_data", 256'(od), 256'(INV16));
    check_eq("nb4_inv_inv", 256'(oi), 256'd1);
    check_eq("nb4_inv_tag", 256'(ot), 256'ha);
    check_eq("nb4_inv_latency", 256'(lat), 256'd1);

    // Forward then inverse returns the original state
    for (int n = 0; n < 1000; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      xfer_a(rnd, 1'b0, 4'(n), od, oi, ot, lat);
      xfer_a(od, 1'b1, 4'(n), rd, oi, ot, lat);
      $display("beat a roundtrip %0d: in=%032h mid=%032h back=%032h", n, rnd, od, rd);
      check_eq("roundtrip", 256'(rd), 256'(rnd));
    end

    // Flush at occupancy 2 with a concurrent input beat
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = IN16; a_in_inv = 0; a_in_tag = 4'h1;
    @(posedge clk);
    @(negedge clk);
    a_in_tag = 4'h2;
    @(posedge clk);
    @(negedge clk);
    check_eq("flush_pre_occ", 256'(a_occ), 256'd2);
    a_flush = 1'b1; a_in_tag = 4'he; a_out_ready = 1'b1;
    #1;
    check_eq("flush_in_ready", 256'(a_in_ready), 256'd0);
    check_eq("flush_out_valid_hold", 256'(a_out_valid), 256'd1);
    @(posedge clk);
    @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0;
    check_eq("flush_post_occ", 256'(a_occ), 256'd0);
    check_eq("flush_post_valid", 256'(a_out_valid), 256'd0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    $display("flush a: beats seen after flush=%0d", seen);
    check_eq("flush_no_ghost", 256'(seen), 256'd0);

    // NB=8 forward vector
    for (int k = 0; k < 32; k++) d8[8*k +: 8] = 8'(k);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = d8; b_in_inv = 1'b0; b_in_tag = 4'h5; b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin @(negedge clk); lat++; end
    $display("beat b fwd: tag=%0h out=%064h lat=%0d", b_out_tag, b_out_data, lat);
    check_eq("nb8_byte1", 256'(b_out_data[15:8]), 256'h05);
    check_eq("nb8_byte2", 256'(b_out_data[23:16]), 256'h0e);
    check_eq("nb8_byte3", 256'(b_out_data[31:24]), 256'h13);
    check_eq("nb8_byte31", 256'(b_out_data[255:248]), 256'h0f);
    check_eq("nb8_full", b_out_data, sr_model(d8, 8, 1'b0));
    check_eq("nb8_latency", 256'(lat), 256'd2);
    @(negedge clk);

    // Backpressure stream of 10 beats, alternating modes
    for (int k = 0; k < 10; k++) begin
      bp_data[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    t_in = 0; rx = 0; cyc = 0; prev_stalled = 1'b0; prev_data = '0; prev_tag = '0;
    while (rx < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_valid  = (t_in < 10);
      b_in_data   = bp_data[t_in % 10];
      b_in_inv    = 1'(t_in % 2);
      b_in_tag    = 4'(t_in);
      #1;
      check_eq("bp_occupancy", 256'(b_occ), 256'(t_in - rx));
      check_eq("bp_in_ready", 256'(b_in_ready), 256'(!((t_in - rx) == 3 && !b_out_ready)));
      if (prev_stalled) begin
        check_eq("bp_stall_data", b_out_data, prev_data);
        check_eq("bp_stall_tag", 256'(b_out_tag), 256'(prev_tag));
      end
      will_in  = b_in_valid && b_in_ready;
      will_out = b_out_valid && b_out_ready;
      if (will_out) begin
        $display("beat b out: tag=%0h inv=%0b cycle=%0d", b_out_tag, b_out_inv, cyc);
        check_eq("bp_tag_order", 256'(b_out_tag), 256'(rx));
        check_eq("bp_inv", 256'(b_out_inv), 256'(rx % 2));
        check_eq("bp_data", b_out_data, sr_model(bp_data[rx], 8, 1'(rx % 2)));
      end
      prev_stalled = b_out_valid && !b_out_ready;
      prev_data    = b_out_data;
      prev_tag     = b_out_tag;
      @(posedge clk);
      if (will_in) t_in++;
      if (will_out) rx++;
    end
    b_in_valid = 1'b0;
    check_eq("bp_all_received", 256'(rx), 256'd10);

    // Asynchronous reset mid-stream on instance A
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = IN16; a_in_inv = 0; a_in_tag = 4'h7;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    check_eq("arst_pre_valid", 256'(a_out_valid), 256'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("reset a mid-stream: valid=%0b data=%032h occ=%0d", a_out_valid, a_out_data, a_occ);
    check_eq("arst_out_valid", 256'(a_out_valid), 256'd0);
    check_eq("arst_out_data", 256'(a_out_data), 256'd0);
    check_eq("arst_out_tag", 256'(a_out_tag), 256'd0);
    check_eq("arst_out_inv", 256'(a_out_inv), 256'd0);
    check_eq("arst_occ", 256'(a_occ), 256'd0);
    #1 rst_n = 1'b1;
    xfer_a(IN16, 1'b0, 4'hc, od, oi, ot, lat);
    $display("beat a after reset: tag=%0h out=%032h lat=%0d", ot, od, lat);
    check_eq("resume_data", 256'(od), 256'(FWD16));
    check_eq("resume_tag", 256'(ot), 256'hc);
    check_eq("resume_latency", 256'(lat), 256'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
